// File: rtl/apb_arbiter_2to1_if.sv
// Bus bundle for the 2:1 APB arbiter: two requester ports and one downstream completer port.
// The master modport is the arbiter's view; slave is the surrounding environment's view.
interface apb_arbiter_2to1_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  m0_psel;
  logic                  m0_penable;
  logic                  m0_pwrite;
  logic [ADDR_WIDTH-1:0] m0_paddr;
  logic [DATA_WIDTH-1:0] m0_pwdata;
  logic [STRB_WIDTH-1:0] m0_pstrb;
  logic                  m0_pready;
  logic                  m0_pslverr;
  logic [DATA_WIDTH-1:0] m0_prdata;

  logic                  m1_psel;
  logic                  m1_penable;
  logic                  m1_pwrite;
  logic [ADDR_WIDTH-1:0] m1_paddr;
  logic [DATA_WIDTH-1:0] m1_pwdata;
  logic [STRB_WIDTH-1:0] m1_pstrb;
  logic                  m1_pready;
  logic                  m1_pslverr;
  logic [DATA_WIDTH-1:0] m1_prdata;

  logic                  s_psel;
  logic                  s_penable;
  logic                  s_pwrite;
  logic [ADDR_WIDTH-1:0] s_paddr;
  logic [DATA_WIDTH-1:0] s_pwdata;
  logic [STRB_WIDTH-1:0] s_pstrb;
  logic                  s_pready;
  logic                  s_pslverr;
  logic [DATA_WIDTH-1:0] s_prdata;

  modport master (
    input  m0_psel, m0_penable, m0_pwrite, m0_paddr, m0_pwdata, m0_pstrb,
    output m0_pready, m0_pslverr, m0_prdata,
    input  m1_psel, m1_penable, m1_pwrite, m1_paddr, m1_pwdata, m1_pstrb,
    output m1_pready, m1_pslverr, m1_prdata,
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
    input  s_pready, s_pslverr, s_prdata
  );

  modport slave (
    output m0_psel, m0_penable, m0_pwrite, m0_paddr, m0_pwdata, m0_pstrb,
    input  m0_pready, m0_pslverr, m0_prdata,
    output m1_psel, m1_penable, m1_pwrite, m1_paddr, m1_pwdata, m1_pstrb,
    input  m1_pready, m1_pslverr, m1_prdata,
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb,
    output s_pready, s_pslverr, s_prdata
  );
endinterface

// File: rtl/apb_arbiter_2to1.sv
// Round-robin 2:1 APB arbiter: registers the winning request, replays it downstream as
// SETUP/ACCESS, and returns a one-cycle registered completion to its owner.
module apb_arbiter_2to1 #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned TIMEOUT_BITS = $clog2(TIMEOUT + 1)
) (
  input logic                clk,
  input logic                rst,
  apb_arbiter_2to1_if.master bus
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_WIDTH  = (TIMEOUT_BITS == 0) ? 1 : TIMEOUT_BITS;
  localparam bit          TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [STRB_WIDTH-1:0] pstrb;
  } req_t;

  state_t               state, state_next;
  logic                 grant, grant_next, last_grant;
  logic                 launch, done_ok, done_to;
  logic [CNT_WIDTH-1:0] cnt;
  req_t                 req0, req1, req_sel;

  // penable from requesters plays no part in arbitration
  logic unused_penable;
  assign unused_penable = bus.m0_penable ^ bus.m1_penable;

  assign req0    = {bus.m0_pwrite, bus.m0_paddr, bus.m0_pwdata, bus.m0_pstrb};
  assign req1    = {bus.m1_pwrite, bus.m1_paddr, bus.m1_pwdata, bus.m1_pstrb};
  assign req_sel = grant_next ? req1 : req0;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, arbitration and completion strobes
  always_comb begin
    state_next = state;
    grant_next = grant;
    launch     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.m0_psel || bus.m1_psel) begin
          launch     = 1'b1;
          grant_next = (bus.m0_psel && bus.m1_psel) ? ~last_grant : bus.m1_psel;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (bus.s_pready) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
          done_to    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered datapath and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant         <= 1'b0;
      last_grant    <= 1'b1;
      cnt           <= '0;
      bus.s_psel    <= 1'b0;
      bus.s_penable <= 1'b0;
      bus.s_pwrite  <= 1'b0;
      bus.s_paddr   <= '0;
      bus.s_pwdata  <= '0;
      bus.s_pstrb   <= '0;
      bus.m0_pready <= 1'b0;
      bus.m0_pslverr <= 1'b0;
      bus.m0_prdata <= '0;
      bus.m1_pready <= 1'b0;
      bus.m1_pslverr <= 1'b0;
      bus.m1_prdata <= '0;
    end else begin
      bus.s_psel     <= (state_next == SETUP) || (state_next == ACCESS);
      bus.s_penable  <= (state_next == ACCESS);
      cnt            <= ((state == ACCESS) && (state_next == ACCESS)) ? cnt + CNT_WIDTH'(1) : '0;
      bus.m0_pready  <= 1'b0;
      bus.m0_pslverr <= 1'b0;
      bus.m1_pready  <= 1'b0;
      bus.m1_pslverr <= 1'b0;

      if (launch) begin
        grant        <= grant_next;
        last_grant   <= grant_next;
        bus.s_pwrite <= req_sel.pwrite;
        bus.s_paddr  <= req_sel.paddr;
        bus.s_pwdata <= req_sel.pwdata;
        bus.s_pstrb  <= req_sel.pstrb;
      end

      // Completion goes only to the owner; writes leave its prdata untouched
      if (done_ok || done_to) begin
        if (grant) begin
          bus.m1_pready  <= 1'b1;
          bus.m1_pslverr <= done_to | bus.s_pslverr;
          if (done_to)            bus.m1_prdata <= '0;
          else if (!bus.s_pwrite) bus.m1_prdata <= bus.s_prdata;
        end else begin
          bus.m0_pready  <= 1'b1;
          bus.m0_pslverr <= done_to | bus.s_pslverr;
          if (done_to)            bus.m0_prdata <= '0;
          else if (!bus.s_pwrite) bus.m0_prdata <= bus.s_prdata;
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_arbiter_2to1.sv
// Directed bench for apb_arbiter_2to1: table of single transfers plus hand-written
// sequences for round-robin, reset mid-transfer and request withdrawal.
module tb_apb_arbiter_2to1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_arbiter_2to1_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut_if ();

  apb_arbiter_2to1 #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned who;
    bit          wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int unsigned wait_n;
    logic [31:0] rdata;
    bit          err;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int unsigned exp_lat;
  } vec_t;

  function automatic vec_t mk(int unsigned who, bit wr, logic [15:0] a, logic [31:0] d,
                              logic [3:0] s, int unsigned w, logic [31:0] rd, bit e,
                              logic [31:0] xr, bit xe, int unsigned lat);
    vec_t v;
    v.who = who; v.wr = wr; v.addr = a; v.wdata = d; v.strb = s; v.wait_n = w;
    v.rdata = rd; v.err = e; v.exp_rdata = xr; v.exp_err = xe; v.exp_lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Completer model: answers after wait_n ACCESS cycles, ready asserted outside ACCESS as noise
  int unsigned comp_wait = 0;
  logic [31:0] comp_rdata = '0;
  bit          comp_err = 1'b0;
  int unsigned acc_cnt = 0;
  initial begin
    dut_if.s_pready = 1'b0; dut_if.s_pslverr = 1'b0; dut_if.s_prdata = '0;
  end
  always @(negedge clk) begin
    if (dut_if.s_psel && dut_if.s_penable) begin
      if (acc_cnt == comp_wait) begin
        dut_if.s_pready = 1'b1; dut_if.s_prdata = comp_rdata; dut_if.s_pslverr = comp_err;
      end else begin
        dut_if.s_pready = 1'b0; dut_if.s_prdata = 32'hBAD0BAD0; dut_if.s_pslverr = 1'b1;
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      dut_if.s_pready = 1'b1; dut_if.s_prdata = 32'hBAD1BAD1; dut_if.s_pslverr = 1'b1;
    end
  end

  // Bus monitor
  int          setups = 0, unstable = 0, rdy0 = 0, rdy1 = 0, stray_err = 0;
  logic        cap_write = 1'b0;
  logic [15:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_strb = '0;
  always @(negedge clk) begin
    if (!rst && dut_if.s_psel && !dut_if.s_penable) begin
      setups++;
      cap_write = dut_if.s_pwrite; cap_addr = dut_if.s_paddr;
      cap_wdata = dut_if.s_pwdata; cap_strb = dut_if.s_pstrb;
    end else if (!rst && dut_if.s_psel && dut_if.s_penable) begin
      if (dut_if.s_paddr !== cap_addr || dut_if.s_pwrite !== cap_write ||
          dut_if.s_pwdata !== cap_wdata || dut_if.s_pstrb !== cap_strb) unstable++;
    end
    if (dut_if.m0_pready) rdy0++;
    if (dut_if.m1_pready) rdy1++;
    if ((dut_if.m0_pslverr && !dut_if.m0_pready) || (dut_if.m1_pslverr && !dut_if.m1_pready))
      stray_err++;
  end

  task automatic set_req(input int unsigned who, input bit wr, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    if (who == 0) begin
      dut_if.m0_psel = 1'b1; dut_if.m0_penable = 1'b0; dut_if.m0_pwrite = wr;
      dut_if.m0_paddr = a; dut_if.m0_pwdata = d; dut_if.m0_pstrb = s;
    end else begin
      dut_if.m1_psel = 1'b1; dut_if.m1_penable = 1'b0; dut_if.m1_pwrite = wr;
      dut_if.m1_paddr = a; dut_if.m1_pwdata = d; dut_if.m1_pstrb = s;
    end
  endtask

  task automatic clear_req(input int unsigned who);
    if (who == 0) begin dut_if.m0_psel = 1'b0; dut_if.m0_penable = 1'b0; end
    else          begin dut_if.m1_psel = 1'b0; dut_if.m1_penable = 1'b0; end
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    int          lat = 0;
    bit          seen = 1'b0;
    logic [31:0] got_rdata = '0;
    logic        got_err = 1'b0;
    int          other_base, unst_base;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    comp_wait = v.wait_n; comp_rdata = v.rdata; comp_err = v.err;
    other_base = (v.who == 0) ? rdy1 : rdy0;
    unst_base  = unstable;
    set_req(v.who, v.wr, v.addr, v.wdata, v.strb);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (c == 1) check({tag, " s_psel@1"}, 32'(dut_if.s_psel), 32'd1);
      if (c == 2) check({tag, " s_penable@2"}, 32'(dut_if.s_penable), 32'd1);
      if ((v.who == 0) ? dut_if.m0_pready : dut_if.m1_pready) begin
        seen = 1'b1; lat = c;
        got_rdata = (v.who == 0) ? dut_if.m0_prdata : dut_if.m1_prdata;
        got_err   = (v.who == 0) ? dut_if.m0_pslverr : dut_if.m1_pslverr;
      end
    end
    clear_req(v.who);
    check({tag, " completed"}, 32'(seen), 32'd1);
    @(negedge clk);
    check({tag, " latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, " prdata"}, got_rdata, v.exp_rdata);
    check({tag, " pslverr"}, 32'(got_err), 32'(v.exp_err));
    check({tag, " s_paddr"}, 32'(cap_addr), 32'(v.addr));
    check({tag, " s_pwrite"}, 32'(cap_write), 32'(v.wr));
    check({tag, " s_pwdata"}, cap_wdata, v.wdata);
    check({tag, " s_pstrb"}, 32'(cap_strb), 32'(v.strb));
    check({tag, " addr stable"}, 32'(unstable - unst_base), 32'd0);
    check({tag, " other pready"}, 32'((v.who == 0) ? rdy1 : rdy0), 32'(other_base));
    check({tag, " pready 1 cycle"},
          32'((v.who == 0) ? dut_if.m0_pready : dut_if.m1_pready), 32'd0);
  endtask

  vec_t vecs[6];
  int   order[16];
  bit   owner_ok[16];

  initial begin
    dut_if.m0_psel = 0; dut_if.m0_penable = 0; dut_if.m0_pwrite = 0;
    dut_if.m0_paddr = '0; dut_if.m0_pwdata = '0; dut_if.m0_pstrb = '0;
    dut_if.m1_psel = 0; dut_if.m1_penable = 0; dut_if.m1_pwrite = 0;
    dut_if.m1_paddr = '0; dut_if.m1_pwdata = '0; dut_if.m1_pstrb = '0;

    // who wr addr wdata strb wait rdata err | exp_rdata exp_err latency
    vecs[0] = mk(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0,   32'h55AA55AA, 1'b0, 32'h00000000, 1'b0, 3);
    vecs[1] = mk(1, 1'b0, 16'h0200, 32'h00000000, 4'hF, 5,   32'h12345678, 1'b1, 32'h12345678, 1'b1, 8);
    vecs[2] = mk(0, 1'b0, 16'h0044, 32'h00000000, 4'hF, 0,   32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 3);
    vecs[3] = mk(1, 1'b1, 16'h0300, 32'h0BADF00D, 4'h3, 2,   32'hFFFFFFFF, 1'b0, 32'h12345678, 1'b0, 5);
    vecs[4] = mk(0, 1'b0, 16'h0F00, 32'h00000000, 4'hF, 100, 32'h77777777, 1'b0, 32'h00000000, 1'b1, 10);
    vecs[5] = mk(0, 1'b0, 16'h0020, 32'h00000000, 4'hF, 1,   32'h00001111, 1'b1, 32'h00001111, 1'b1, 4);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst s_psel", 32'(dut_if.s_psel), 32'd0);
    check("rst s_penable", 32'(dut_if.s_penable), 32'd0);
    check("rst s_paddr", 32'(dut_if.s_paddr), 32'd0);
    check("rst m0_pready", 32'(dut_if.m0_pready), 32'd0);
    check("rst m1_pready", 32'(dut_if.m1_pready), 32'd0);
    check("rst m0_prdata", dut_if.m0_prdata, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i], i);

    // Both requesters continuously active from reset: grants alternate starting with m0
    begin
      int n0 = 0, n1 = 0, k = 0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); @(negedge clk);
      comp_wait = 0; comp_rdata = 32'hA5A50000; comp_err = 1'b0;
      set_req(0, 1'b1, 16'h0100, 32'h11112222, 4'hF);
      set_req(1, 1'b0, 16'h0104, 32'h0, 4'hF);
      rst = 1'b0;
      for (int c = 0; c < 80 && k < 8; c++) begin
        @(negedge clk);
        if (dut_if.m0_pready && k < 16) begin
          order[k] = 0; owner_ok[k] = (cap_addr == 16'h0100); k++; n0++;
          if (n0 == 4) clear_req(0);
        end
        if (dut_if.m1_pready && k < 16) begin
          order[k] = 1; owner_ok[k] = (cap_addr == 16'h0104); k++; n1++;
          if (n1 == 4) clear_req(1);
        end
      end
      clear_req(0); clear_req(1);
      check("rr transfers", 32'(k), 32'd8);
      for (int i = 0; i < 8 && i < k; i++) begin
        check($sformatf("rr grant%0d", i), 32'(order[i]), 32'(i % 2));
        check($sformatf("rr owner%0d", i), 32'(owner_ok[i]), 32'd1);
      end
      check("rr m1_prdata", dut_if.m1_prdata, 32'hA5A50000);
    end

    // Reset during ACCESS, then simultaneous requests go to m0 first
    begin
      bit in_access = 1'b0, got0 = 1'b0, got1 = 1'b0;
      @(negedge clk);
      comp_wait = 100;
      set_req(1, 1'b0, 16'h0500, 32'h0, 4'hF);
      for (int c = 0; c < 10 && !in_access; c++) begin
        @(negedge clk);
        in_access = dut_if.s_psel && dut_if.s_penable;
      end
      check("mid reached ACCESS", 32'(in_access), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async s_psel", 32'(dut_if.s_psel), 32'd0);
      check("async s_penable", 32'(dut_if.s_penable), 32'd0);
      check("async s_paddr", 32'(dut_if.s_paddr), 32'd0);
      check("async m1_prdata", dut_if.m1_prdata, 32'd0);
      check("async m1_pready", 32'(dut_if.m1_pready), 32'd0);
      clear_req(1);
      @(negedge clk); @(negedge clk);
      comp_wait = 0; comp_rdata = 32'h0000BEEF; comp_err = 1'b0;
      set_req(0, 1'b0, 16'h0600, 32'h0, 4'hF);
      set_req(1, 1'b0, 16'h0700, 32'h0, 4'hF);
      rst = 1'b0;
      for (int c = 0; c < 20 && !got0 && !got1; c++) begin
        @(negedge clk);
        got0 = dut_if.m0_pready; got1 = dut_if.m1_pready;
      end
      check("post-rst first is m0", 32'(got0), 32'd1);
      check("post-rst m1 not first", 32'(got1), 32'd0);
      check("post-rst s_paddr", 32'(cap_addr), 32'h0600);
      clear_req(0);
      got1 = 1'b0;
      for (int c = 0; c < 20 && !got1; c++) begin
        @(negedge clk);
        got1 = dut_if.m1_pready;
      end
      clear_req(1);
      check("post-rst m1 served", 32'(got1), 32'd1);
    end

    // m1 psel pulse during m0 transfer is never served
    begin
      int  setup_base, rdy1_base, lat = 0;
      bit  seen = 1'b0;
      repeat (2) @(negedge clk);
      setup_base = setups; rdy1_base = rdy1;
      comp_wait = 3; comp_rdata = 32'h0; comp_err = 1'b0;
      set_req(0, 1'b1, 16'h0800, 32'h01020304, 4'h1);
      for (int c = 1; c <= 30 && !seen; c++) begin
        @(negedge clk);
        if (c == 2) set_req(1, 1'b1, 16'h0900, 32'hFFFF0000, 4'hF);
        if (c == 3) clear_req(1);
        if (dut_if.m0_pready) begin seen = 1'b1; lat = c; end
      end
      clear_req(0);
      repeat (6) @(negedge clk);
      check("pulse m0 latency", 32'(lat), 32'd6);
      check("pulse setups", 32'(setups - setup_base), 32'd1);
      check("pulse m1 pready", 32'(rdy1 - rdy1_base), 32'd0);
      check("stray pslverr", 32'(stray_err), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apb_arbiter_2to1.md
Name: apb_arbiter_2to1

Overview:
- Two-requester APB arbiter. It shares one downstream APB completer segment, such as a root-bridge port or a peripheral bus, between two APB requesters. Typical requesters are the FMC bridge path and a future on-chip master (DMA, UART console engine).
- Arbitration is round-robin. Requests are registered and re-launched downstream as clean APB setup/access phases.
- An optional access timeout terminates hung transfers with an error.

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8
- ADDR_WIDTH, 16, address width
- TIMEOUT, 1024, maximum ACCESS-phase cycles before forced error termination; 0 disables the timeout
- TIMEOUT_BITS, $clog2(TIMEOUT+1), width of the timeout counter

Ports:
- clk  input  1  sole clock; all logic is in this domain
- rst  input  1  asynchronous, active-high reset
- mN_psel, mN_penable, mN_pwrite (N=0,1)  input  1 each  requester N control
- mN_paddr  input  ADDR_WIDTH  requester N address
- mN_pwdata  input  DATA_WIDTH  requester N write data
- mN_pstrb  input  DATA_WIDTH/8  requester N byte strobes
- mN_pready, mN_pslverr  output  1 each  completion to requester N
- mN_prdata  output  DATA_WIDTH  read data to requester N
- s_psel, s_penable, s_pwrite  output  1 each  downstream control
- s_paddr  output  ADDR_WIDTH  downstream address
- s_pwdata  output  DATA_WIDTH  downstream write data
- s_pstrb  output  DATA_WIDTH/8  downstream byte strobes
- s_pready, s_pslverr  input  1 each  downstream completion
- s_prdata  input  DATA_WIDTH  downstream read data

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE.
  - last_grant = 1, so requester 0 wins the first tie.
  - Timeout counter = 0.
- Request definition: mN_psel=1. mN_penable is ignored for arbitration.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If exactly one requester is active, grant it.
  - If both are active, grant the requester != last_grant.
  - On grant, register that requester's pwrite/paddr/pwdata/pstrb into the s_* registers, set grant and last_grant, then go to SETUP.
  - If no request, stay in IDLE.
- SETUP: s_psel=1, s_penable=0; go to ACCESS next cycle.
- ACCESS:
  - s_psel=1, s_penable=1.
  - If s_pready=1: capture s_prdata (reads only; otherwise keep the previous value) and s_pslverr, then go to RESP.
  - Else if TIMEOUT!=0 and the counter reaches TIMEOUT-1: capture prdata=0 and pslverr=1, then go to RESP.
  - The counter increments each ACCESS cycle and clears on leaving ACCESS.
- RESP:
  - s_psel=s_penable=0.
  - Granted requester sees pready=1, prdata and pslverr from the captured values, for exactly one cycle.
  - Next state IDLE.
- Non-granted requester: pready=0 and pslverr=0 at all times. Its prdata holds its last registered value.
- Signal quality: all mN_* and s_* outputs are registered; no combinational path from input to output.
- Latency, sampled request at cycle 0:
  - s_psel=1 at cycle 1; s_penable=1 at cycle 2.
  - With a zero-wait completer (s_pready=1 at cycle 2), mN_pready=1 at cycle 3.
  - Minimum 4 cycles per transfer, including the IDLE re-arbitration cycle.
- Re-arbitration: in the IDLE cycle after RESP, a requester still holding psel (back-to-back) is a new request, subject to round-robin. Requesters must change psel/paddr only after their pready. The arbiter's registers are captured in IDLE, so later changes during the transfer have no effect.
- Stability: s_paddr/s_pwrite/s_pwdata/s_pstrb are stable from SETUP through ACCESS completion. They hold their last value in IDLE/RESP.
- Fairness: under continuous requests from both requesters, grants strictly alternate 0,1,0,1.
- s_pready outside ACCESS is ignored.
- A request dropped by a requester before grant is simply not served; there is no latching of psel pulses.
- Reset mid-transfer forces IDLE immediately, with s_psel=0 and no pready to either requester. The downstream transfer is abandoned.

Test Plan:
1. Single write, zero-wait. m0 writes paddr=0x0010, pwdata=0xDEADBEEF, pstrb=0xF; s_pready is tied to 1 in ACCESS.
   - s_psel rises 1 cycle after the request; s_penable 1 cycle later.
   - m0_pready=1 three cycles after the request, pslverr=0.
   - m1_pready stays 0 throughout.
2. Read with wait states. m1 reads 0x0200; the completer holds s_pready=0 for 5 ACCESS cycles, then returns 0x12345678 with pslverr=1.
   - m1_prdata=0x12345678 and m1_pslverr=1 with m1_pready, 8 cycles after the request.
   - s_paddr is stable throughout.
3. Simultaneous requests out of reset. Both requesters assert psel in the same cycle, continuously, for 4 transfers each.
   - Grants run m0,m1,m0,m1,...; neither requester is starved.
   - Each pready goes only to its owner.
4. Timeout. TIMEOUT=8; the completer never asserts s_pready.
   - After 8 ACCESS cycles, s_psel drops.
   - Requester gets pready=1, pslverr=1, prdata=0. The next request proceeds normally.
5. Reset mid-operation. Assert rst during ACCESS.
   - All outputs go 0 asynchronously.
   - After release, a request with both requesters active is granted to m0 first.
6. Request withdrawal. m1 pulses psel for 1 cycle while m0 is mid-transfer.
   - No downstream transfer for m1; m1_pready is never asserted.
